// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl
//
// Read-side controller of a dual-clock FIFO. Everything here runs on the read
// clock. The Gray write pointer from the write domain is synchronised through
// two flops and compared with the registered Gray read pointer to detect
// empty. The controller owns the binary and Gray read pointers, drives the
// memory read address, and presents words through a registered valid/ready
// output stage, which gives first-word-fall-through behaviour.
//
// Optional feature: define FIFO_RD_LEVEL_EN to get a registered fill level.
// Without it, level is tied to zero and no converter or subtractor is built.
//
// Parameters
//   W   memory address width; pointers are W+1 bits
//   DW  data width
//
// Ports
//   clk       in   read-domain clock
//   rst       in   asynchronous reset, active-high
//   G_WR_PTR  in   Gray write pointer from the write domain (unsynchronised)
//   RD_DATA   in   memory read data, combinational from RD_ADDR
//   rd_ready  in   consumer accepts rd_data this cycle
//   RD_ADDR   out  memory read address, low W bits of the binary read pointer
//   G_RD_PTR  out  registered Gray read pointer, sent to the write domain
//   empty     out  memory holds no unread word (output register not counted)
//   rd_valid  out  rd_data holds a valid word
//   rd_data   out  output data register
//   level     out  words in memory (output register not counted)
// -----------------------------------------------------------------------------
module fifo_rd_ctrl #(
    parameter int W  = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W:0]    G_WR_PTR,
    input  logic [DW-1:0] RD_DATA,
    input  logic          rd_ready,
    output logic [W-1:0]  RD_ADDR,
    output logic [W:0]    G_RD_PTR,
    output logic          empty,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic [W:0]    level
);

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    function automatic logic [W:0] gray(input logic [W:0] b);
        return b ^ (b >> 1);
    endfunction

    state_t     state, state_next;
    logic [W:0] wq1, wq2;
    logic [W:0] rd_ptr, rd_ptr_next;
    logic       load;

    // -------------------------------------------------------------------------
    // Write-pointer synchroniser. Only wq2 is used downstream.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wq1 <= '0;
            wq2 <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value; blocking here would collapse
            // the two synchroniser stages into one.
            wq1 <= G_WR_PTR;
            wq2 <= wq1;
        end
    end

    // Both operands are registers, so empty never glitches from input noise.
    // It lags a write by the synchroniser depth but is never falsely low.
    assign empty    = (G_RD_PTR == wq2);
    assign rd_valid = (state == VALID);
    assign RD_ADDR  = rd_ptr[W-1:0];

    // Load whenever there is a word and the output register is free or being
    // emptied this cycle; accept and load together give zero-bubble streaming.
    assign load = !empty && (!rd_valid || rd_ready);

    // -------------------------------------------------------------------------
    // Output-stage next state and read-pointer advance.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_next  = state;
        rd_ptr_next = rd_ptr;
        if (load) begin
            state_next  = VALID;
            rd_ptr_next = rd_ptr + 1'b1;
        end else if (rd_valid && rd_ready) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            G_RD_PTR <= '0;
            rd_data  <= '0;
        end else begin
            state    <= state_next;
            rd_ptr   <= rd_ptr_next;
            // Registered from the next binary value so the Gray pointer seen
            // by the write domain changes exactly one bit per step.
            G_RD_PTR <= gray(rd_ptr_next);
            if (load) begin
                rd_data <= RD_DATA;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Optional fill level.
    // -------------------------------------------------------------------------
`ifdef FIFO_RD_LEVEL_EN
    logic [W:0] wq2_bin;

    // Bit i of the binary value is the XOR of Gray bits W..i; computing it
    // from the shifted vector avoids a self-referencing combinational chain.
    always_comb begin
        wq2_bin = '0;
        for (int i = 0; i <= W; i++) begin
            wq2_bin[i] = ^(wq2 >> i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else begin
            level <= wq2_bin - rd_ptr;
        end
    end
`else
    assign level = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_ctrl
//
// Self-checking bench for fifo_rd_ctrl with W=4, DW=8. The bench plays the
// write side: it owns a 16-entry memory model, writes words into it, pushes
// each written word onto a scoreboard queue and advances the Gray write
// pointer. Every accepted output word is popped and compared. Inputs change
// and outputs are sampled 1 time unit after the rising clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_rd_ctrl;

    localparam int W  = 4;
    localparam int DW = 8;
    localparam int DEPTH = 1 << W;

    logic          clk;
    logic          rst;
    logic [W:0]    G_WR_PTR;
    logic [DW-1:0] RD_DATA;
    logic          rd_ready;
    logic [W-1:0]  RD_ADDR;
    logic [W:0]    G_RD_PTR;
    logic          empty;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [W:0]    level;

    fifo_rd_ctrl #(.W(W), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .G_WR_PTR (G_WR_PTR),
        .RD_DATA  (RD_DATA),
        .rd_ready (rd_ready),
        .RD_ADDR  (RD_ADDR),
        .G_RD_PTR (G_RD_PTR),
        .empty    (empty),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .level    (level)
    );

    logic [DW-1:0] mem [DEPTH];
    assign RD_DATA = mem[RD_ADDR];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [DW-1:0] exp_q [$];
    logic [W:0]    wr_bin;
    int            accepted;

    function automatic logic [W:0] gray(input logic [W:0] b);
        return b ^ (b >> 1);
    endfunction

    // Write one word into the memory model and publish the new write pointer.
    task automatic write_word(input logic [DW-1:0] d);
        mem[wr_bin[W-1:0]] = d;
        exp_q.push_back(d);
        wr_bin   = wr_bin + 1'b1;
        G_WR_PTR = gray(wr_bin);
    endtask

    // One clock: drive rd_ready, score an accept if one happens on this edge,
    // then advance to 1 time unit past the edge.
    task automatic cycle(input logic ready, output logic acc);
        logic [DW-1:0] e;
        rd_ready = ready;
        acc = rd_valid && ready;
        if (acc) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL accept_unexpected: got word %02h, want no word", rd_data);
            end else begin
                e = exp_q.pop_front();
                if (rd_data !== e) $display("FAIL accept_data: got %02h want %02h", rd_data, e);
                else pass_cnt++;
            end
            accepted++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        rd_ready = 1'b0;
        G_WR_PTR = '0;
        wr_bin   = '0;
        accepted = 0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Wait with rd_ready low until rd_valid rises; expiry is a failed check.
    task automatic wait_valid(input string tag);
        logic acc;
        int n;
        n = 0;
        while (!rd_valid && n < 10) begin
            cycle(1'b0, acc);
            n++;
        end
        if (!rd_valid) begin
            total_cnt++;
            $display("FAIL %s_wait_valid: rd_valid got 0 want 1 within 10 cycles", tag);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        #1;
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %0b want 0", rd_valid); else pass_cnt++;
        total_cnt++; if (RD_ADDR !== '0)    $display("FAIL reset_rd_addr: got %0h want 0", RD_ADDR); else pass_cnt++;
        total_cnt++; if (G_RD_PTR !== '0)   $display("FAIL reset_g_rd_ptr: got %0h want 0", G_RD_PTR); else pass_cnt++;
        total_cnt++; if (empty !== 1'b1)    $display("FAIL reset_empty: got %0b want 1", empty); else pass_cnt++;
        total_cnt++; if (rd_data !== '0)    $display("FAIL reset_rd_data: got %02h want 00", rd_data); else pass_cnt++;
        total_cnt++; if (level !== '0)      $display("FAIL reset_level: got %0h want 0", level); else pass_cnt++;
        apply_reset();
    endtask

    task automatic test_single();
        logic acc;
        logic [DW-1:0] e;
        apply_reset();
        write_word(8'hA5);
        e = exp_q[0];
        cycle(1'b0, acc);  // edge 1: only the first synchroniser stage has it
        total_cnt++; if (empty !== 1'b1) $display("FAIL single_empty_e1: got %0b want 1", empty); else pass_cnt++;
        cycle(1'b0, acc);  // edge 2
        total_cnt++; if (empty !== 1'b0)    $display("FAIL single_empty_e2: got %0b want 0", empty); else pass_cnt++;
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL single_valid_e2: got %0b want 0", rd_valid); else pass_cnt++;
        cycle(1'b0, acc);  // edge 3
        total_cnt++; if (rd_valid !== 1'b1) $display("FAIL single_valid_e3: got %0b want 1", rd_valid); else pass_cnt++;
        total_cnt++; if (rd_data !== e)     $display("FAIL single_data_e3: got %02h want %02h", rd_data, e); else pass_cnt++;
        total_cnt++; if (RD_ADDR !== 4'd1)  $display("FAIL single_addr_e3: got %0h want 1", RD_ADDR); else pass_cnt++;
        total_cnt++; if (G_RD_PTR !== 5'h01) $display("FAIL single_g_rd_ptr_e3: got %0h want 1", G_RD_PTR); else pass_cnt++;
        total_cnt++; if (empty !== 1'b1)    $display("FAIL single_empty_e3: got %0b want 1", empty); else pass_cnt++;
        cycle(1'b1, acc);
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL single_valid_after_accept: got %0b want 0", rd_valid); else pass_cnt++;
    endtask

    task automatic test_stream();
        logic acc;
        int first_acc, last_acc, n;
        apply_reset();
        for (int i = 0; i < 5; i++) write_word(8'h30 + 8'(i));
        total_cnt++; if (G_WR_PTR !== 5'h07) $display("FAIL stream_wr_gray: got %0h want 7", G_WR_PTR); else pass_cnt++;
        first_acc = -1;
        last_acc  = -1;
        n = 0;
        while (accepted < 5 && n < 20) begin
            cycle(1'b1, acc);
            if (acc) begin
                if (first_acc < 0) first_acc = n;
                last_acc = n;
            end
            n++;
        end
        total_cnt++; if (accepted != 5) $display("FAIL stream_count: got %0d words want 5", accepted); else pass_cnt++;
        total_cnt++; if (last_acc - first_acc != 4) $display("FAIL stream_consecutive: got span %0d want 4", last_acc - first_acc); else pass_cnt++;
        total_cnt++; if (rd_valid !== 1'b0)  $display("FAIL stream_valid_end: got %0b want 0", rd_valid); else pass_cnt++;
        total_cnt++; if (G_RD_PTR !== 5'h07) $display("FAIL stream_g_rd_ptr_end: got %0h want 7", G_RD_PTR); else pass_cnt++;
        total_cnt++; if (empty !== 1'b1)     $display("FAIL stream_empty_end: got %0b want 1", empty); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic acc;
        logic [DW-1:0] e;
        int n, got;
        apply_reset();
        for (int i = 0; i < 8; i++) write_word(8'($urandom_range(0, 255)));
        wait_valid("bp");
        e = exp_q[0];
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0, acc);
            total_cnt++; if (rd_data !== e)      $display("FAIL bp_hold_data: cycle %0d got %02h want %02h", c, rd_data, e); else pass_cnt++;
            total_cnt++; if (RD_ADDR !== 4'd1)   $display("FAIL bp_hold_addr: cycle %0d got %0h want 1", c, RD_ADDR); else pass_cnt++;
            total_cnt++; if (G_RD_PTR !== gray(5'd1)) $display("FAIL bp_hold_g_rd_ptr: cycle %0d got %0h want %0h", c, G_RD_PTR, gray(5'd1)); else pass_cnt++;
            total_cnt++; if (empty !== 1'b0)     $display("FAIL bp_hold_empty: cycle %0d got %0b want 0", c, empty); else pass_cnt++;
        end
        n = 0;
        got = 0;
        while (accepted < 8 && n < 20) begin
            cycle(1'b1, acc);
            if (acc) got++;
            n++;
        end
        total_cnt++; if (got != 8 || n != 8) $display("FAIL bp_resume: got %0d words in %0d cycles want 8 in 8", got, n); else pass_cnt++;
        total_cnt++; if (exp_q.size() != 0) $display("FAIL bp_leftover: got %0d queued want 0", exp_q.size()); else pass_cnt++;

        // Reset in the middle of a stream, away from the clock edge.
        apply_reset();
        for (int i = 0; i < 3; i++) write_word(8'hC0 + 8'(i));
        wait_valid("midrst");
        #2;
        rst = 1'b1;
        #1;
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL midrst_rd_valid: got %0b want 0", rd_valid); else pass_cnt++;
        total_cnt++; if (RD_ADDR !== '0)    $display("FAIL midrst_rd_addr: got %0h want 0", RD_ADDR); else pass_cnt++;
        total_cnt++; if (G_RD_PTR !== '0)   $display("FAIL midrst_g_rd_ptr: got %0h want 0", G_RD_PTR); else pass_cnt++;
        total_cnt++; if (empty !== 1'b1)    $display("FAIL midrst_empty: got %0b want 1", empty); else pass_cnt++;
        total_cnt++; if (rd_data !== '0)    $display("FAIL midrst_rd_data: got %02h want 00", rd_data); else pass_cnt++;
        apply_reset();
    endtask

    task automatic test_wrap();
        logic acc;
        logic [W-1:0] prev_addr;
        logic [W:0]   prev_g;
        int written, n, addr_wraps, g_half, g_full, bad_steps;
        apply_reset();
        written = 0;
        n = 0;
        addr_wraps = 0;
        g_half = 0;
        g_full = 0;
        bad_steps = 0;
        while (accepted < 40 && n < 400) begin
            if (written < 40 && int'(5'(wr_bin - 5'(accepted))) < DEPTH) begin
                write_word(8'($urandom_range(0, 255)));
                written++;
            end
            prev_addr = RD_ADDR;
            prev_g    = G_RD_PTR;
            cycle($urandom_range(0, 3) != 0, acc);
            if (prev_addr == 4'd15 && RD_ADDR == 4'd0) addr_wraps++;
            if (prev_g == 5'h08 && G_RD_PTR == 5'h18) g_half++;
            if (prev_g == 5'h10 && G_RD_PTR == 5'h00) g_full++;
            if (RD_ADDR != prev_addr && RD_ADDR != prev_addr + 1'b1) bad_steps++;
            n++;
        end
        total_cnt++; if (accepted != 40)   $display("FAIL wrap_count: got %0d words want 40", accepted); else pass_cnt++;
        total_cnt++; if (addr_wraps != 2)  $display("FAIL wrap_addr_15_to_0: got %0d want 2", addr_wraps); else pass_cnt++;
        total_cnt++; if (g_half != 1)      $display("FAIL wrap_g_08_to_18: got %0d want 1", g_half); else pass_cnt++;
        total_cnt++; if (g_full != 1)      $display("FAIL wrap_g_10_to_00: got %0d want 1", g_full); else pass_cnt++;
        total_cnt++; if (bad_steps != 0)   $display("FAIL wrap_addr_step: got %0d bad steps want 0", bad_steps); else pass_cnt++;
        total_cnt++; if (RD_ADDR !== 4'd8) $display("FAIL wrap_addr_end: got %0h want 8", RD_ADDR); else pass_cnt++;
        total_cnt++; if (G_RD_PTR !== 5'h0C) $display("FAIL wrap_g_rd_ptr_end: got %0h want c", G_RD_PTR); else pass_cnt++;
        total_cnt++; if (rd_valid !== 1'b0) $display("FAIL wrap_valid_end: got %0b want 0", rd_valid); else pass_cnt++;
    endtask

`ifdef FIFO_RD_LEVEL_EN
    task automatic test_level();
        logic acc;
        logic [W:0] e;
        int n;
        apply_reset();
        for (int i = 0; i < 10; i++) write_word(8'h50 + 8'(i));
        n = 0;
        // Two accepts leave a third word loaded in the output register, so
        // three words have left memory.
        while (accepted < 2 && n < 20) begin
            cycle(1'b1, acc);
            n++;
        end
        for (int c = 0; c < 3; c++) cycle(1'b0, acc);
        e = wr_bin - 5'(accepted + 1);
        total_cnt++; if (level !== e) $display("FAIL level_partial: got %0d want %0d", level, e); else pass_cnt++;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            cycle(1'b1, acc);
            n++;
        end
        for (int c = 0; c < 2; c++) cycle(1'b0, acc);
        total_cnt++; if (level !== '0)   $display("FAIL level_drained: got %0d want 0", level); else pass_cnt++;
        total_cnt++; if (empty !== 1'b1) $display("FAIL level_empty: got %0b want 1", empty); else pass_cnt++;
    endtask
`endif

    initial begin
        rst      = 1'b1;
        rd_ready = 1'b0;
        G_WR_PTR = '0;
        wr_bin   = '0;
        accepted = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_wrap();
`ifdef FIFO_RD_LEVEL_EN
        test_level();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
